// File: rtl/wfq_finish_tag_if.sv
// Arrival request and stamped-tag result bundle for the WFQ finish-tag stage.
interface wfq_finish_tag_if #(
   parameter int FLOW_BITS = 13,
   parameter int TAG_W     = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [FLOW_BITS-1:0] flow_id;
   logic [15:0]          pkt_len;
   logic [15:0]          sum_w;
   logic [15:0]          flow_w;
   logic [15:0]          delta_t;
   logic                 flow_idle;
   logic                 out_valid;
   logic [FLOW_BITS-1:0] out_flow_id;
   logic [TAG_W-1:0]     out_tag;
   logic [TAG_W-1:0]     vtime;

   modport master (
      output in_valid, flow_id, pkt_len, sum_w, flow_w, delta_t, flow_idle,
      input  in_ready, out_valid, out_flow_id, out_tag, vtime
   );

   modport slave (
      input  in_valid, flow_id, pkt_len, sum_w, flow_w, delta_t, flow_idle,
      output in_ready, out_valid, out_flow_id, out_tag, vtime
   );
endinterface

// File: rtl/wfq_finish_tag.sv
// WFQ finish-tag stage: advances virtual time by delta_t/sum_w, then stamps
// F = later(F_last, V) + pkt_len/flow_w using one shared serial divider.
//
// state | meaning
// IDLE  | ready for an arrival; accept latches inputs and reads F_last
// DIV_V | DW-cycle division delta_t/sum_w; last cycle updates V
// DIV_F | DW-cycle division pkt_len/flow_w; last cycle forms F
// DONE  | out_valid pulse, F written back to the per-flow table
module wfq_finish_tag #(
   parameter int FLOW_BITS = 13,
   parameter int FRAC      = 8,
   parameter int TAG_W     = 32
) (
   input  logic            clk,
   input  logic            rst,
   wfq_finish_tag_if.slave bus
);
   localparam int DW = 16 + FRAC;
   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, DIV_V, DIV_F, DONE} state_t;
   state_t state_q, state_d;

   logic [FLOW_BITS-1:0] flow_q, out_flow_q;
   logic [15:0]          len_q, fw_q, dvs_q, rem_q, rem_d;
   logic                 idle_q, zero_q, out_valid_q;
   logic [DW-1:0]        dvd_q, dvd_d, quo;
   logic [CW-1:0]        cnt_q;
   logic [TAG_W-1:0]     v_q, v_d, f_d, out_tag_q, rd_q, start, diff;
   logic [16:0]          rem_sh;
   logic                 ge, last, accept, load_f;

   // Per-flow last finish tag; RAM contents survive reset on purpose.
   logic [TAG_W-1:0] mem [2**FLOW_BITS];

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = out_valid_q;
   assign bus.out_flow_id = out_flow_q;
   assign bus.out_tag     = out_tag_q;
   assign bus.vtime       = v_q;

   // One restoring-division step, plus the V update and the tag arithmetic.
   always_comb begin
      rem_sh = {rem_q, dvd_q[DW-1]};
      ge     = (rem_sh >= {1'b0, dvs_q});
      rem_d  = ge ? 16'(rem_sh - {1'b0, dvs_q}) : rem_sh[15:0];
      dvd_d  = {dvd_q[DW-2:0], ge};
      // A zero sum_w would yield all-ones; force the quotient to zero instead.
      quo    = zero_q ? '0 : dvd_d;
      last   = (cnt_q == '0);
      v_d    = v_q + TAG_W'(quo);
      // Serial-number compare: F_last is later only if strictly ahead by < half range.
      diff   = rd_q - v_q;
      start  = (idle_q || diff == '0 || diff[TAG_W-1]) ? v_q : rd_q;
      f_d    = start + TAG_W'(quo);
   end

   // Next-state decode and the load strobes for the divider.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      load_f  = 1'b0;
      case (state_q)
         IDLE:  if (bus.in_valid) begin
                   accept  = 1'b1;
                   state_d = DIV_V;
                end
         DIV_V: if (last) begin
                   load_f  = 1'b1;
                   state_d = DIV_F;
                end
         DIV_F: if (last) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Request latch, divider iteration, virtual time and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flow_q      <= '0;
         len_q       <= '0;
         fw_q        <= '0;
         idle_q      <= 1'b0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         zero_q      <= 1'b0;
         cnt_q       <= '0;
         v_q         <= '0;
         out_tag_q   <= '0;
         out_flow_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (accept) begin
            flow_q <= bus.flow_id;
            len_q  <= bus.pkt_len;
            fw_q   <= bus.flow_w;
            idle_q <= bus.flow_idle;
            dvd_q  <= {bus.delta_t, {FRAC{1'b0}}};
            dvs_q  <= bus.sum_w;
            zero_q <= (bus.sum_w == 16'd0);
            rem_q  <= '0;
            cnt_q  <= CW'(DW - 1);
         end else if (load_f) begin
            v_q    <= v_d;
            dvd_q  <= {len_q, {FRAC{1'b0}}};
            dvs_q  <= (fw_q == 16'd0) ? 16'd1 : fw_q;
            zero_q <= 1'b0;
            rem_q  <= '0;
            cnt_q  <= CW'(DW - 1);
         end else if (state_q == DIV_V || state_q == DIV_F) begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
            if (state_q == DIV_F && last) begin
               out_tag_q   <= f_d;
               out_flow_q  <= flow_q;
               out_valid_q <= 1'b1;
            end
         end
      end
   end

   // Tag table: read on accept, write back the stamped tag in DONE.
   always_ff @(posedge clk) begin
      if (accept)           rd_q <= mem[bus.flow_id];
      if (state_q == DONE)  mem[flow_q] <= out_tag_q;
   end
endmodule
